vga_fetch_arbiter: RTL and testbench

VGA_FETCH_ARBITER -- requirements
Module: vga_fetch_arbiter

---
 rtl/vga_fetch_arbiter.sv | 133 +++++++++++++
 tb/tb_vga_fetch_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_fetch_arbiter.sv
// rtl/vga_fetch_arbiter.sv - single-port SRAM slot arbiter: display fetch, host write FIFO, 1bpp pixel shifter
module vga_fetch_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [8:0]        row,
    input  logic [9:0]        col,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              pixel,
    output logic              pixel_valid
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic              active;
    logic              fetch_mid;
    logic              fetch_eol;
    logic              fetch;
    logic [8:0]        next_line;
    logic [8:0]        fetch_line;
    logic [6:0]        fetch_word;
    logic [9:0]        col_plus2;
    logic [ADDR_W-1:0] line_ext;
    logic [ADDR_W-1:0] fetch_addr;
    logic [6:0]        shift;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign wr_ready = !full;
    assign push     = wr_valid && !full;

    assign active    = (col < 10'd640) && (row < 9'd480);
    assign next_line = (row == 9'd524) ? 9'd0 : row + 9'd1;
    assign col_plus2 = col + 10'd2;

    // Mid-line fetch two columns ahead of the word boundary; col 798 prefetches word 0 of the next line
    assign fetch_mid = (col[2:0] == 3'd6) && (col < 10'd632) && (row < 9'd480);
    assign fetch_eol = (col == 10'd798) && (next_line < 9'd480);
    assign fetch     = fetch_mid || fetch_eol;
    assign pop       = !fetch && !empty;

    assign fetch_line = fetch_eol ? next_line : row;
    assign fetch_word = fetch_eol ? 7'd0 : col_plus2[9:3];
    assign line_ext   = ADDR_W'(fetch_line);
    assign fetch_addr = (line_ext << 6) + (line_ext << 4) + ADDR_W'(fetch_word);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_re <= fetch;
            mem_we <= pop;
            if (fetch) begin
                mem_addr <= fetch_addr;
            end else if (pop) begin
                mem_addr  <= fifo_addr[rd_ptr];
                mem_wdata <= fifo_data[rd_ptr];
            end
        end
    end

    // Read data lands in the col[2:0]==0 cycle, so the word loads exactly on its first pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel       <= 1'b0;
            pixel_valid <= 1'b0;
            shift       <= '0;
        end else begin
            pixel_valid <= active;
            if (!active) begin
                pixel <= 1'b0;
            end else if (col[2:0] == 3'd0) begin
                pixel <= mem_rdata[7];
                shift <= mem_rdata[6:0];
            end else begin
                pixel <= shift[6];
                shift <= {shift[5:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// tb/tb_vga_fetch_arbiter.sv - directed self-checking bench for vga_fetch_arbiter
module tb_vga_fetch_arbiter;

    localparam int AW = 16;

    logic          clk;
    logic          rst_n;
    logic [8:0]    row;
    logic [9:0]    col;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          pixel;
    logic          pixel_valid;

    int            vectors;
    int            miscompares;
    int            hn;
    logic          accepted;
    logic [AW+7:0] sb [$];
    logic [7:0]    pat;

    vga_fetch_arbiter #(.FIFO_DEPTH(4), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row         (row),
        .col         (col),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pixel       (pixel),
        .pixel_valid (pixel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_host();
        wr_addr = AW'(32'hA000 + hn);
        wr_data = 8'(hn * 37 + 5);
    endtask

    // One cycle with the given row/col; outputs are sampled 1 time unit after the edge
    task automatic step(input logic [8:0] r, input logic [9:0] c);
        row = r;
        col = c;
        @(negedge clk);
        accepted = wr_valid && wr_ready;
        if (accepted) sb.push_back({wr_addr, wr_data});
        @(posedge clk);
        #1;
        if (mem_we) begin
            chk("re_we_exclusive", {31'd0, mem_re}, 32'd0);
            chk("we_pending", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) chk("we_word", {8'd0, mem_addr, mem_wdata}, {8'd0, sb.pop_front()});
        end
        if (accepted) begin
            hn++;
            set_host();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        hn          = 0;
        rst_n       = 1'b0;
        row         = '0;
        col         = '0;
        wr_valid    = 1'b0;
        mem_rdata   = '0;
        set_host();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_pixel_valid", {31'd0, pixel_valid}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        rst_n = 1'b1;

        // Fetch addressing
        step(9'd9, 10'd798);
        chk("eol_r9_re", {31'd0, mem_re}, 32'd1);
        chk("eol_r9_addr", {16'd0, mem_addr}, 32'd800);
        step(9'd479, 10'd798);
        chk("eol_r479_re", {31'd0, mem_re}, 32'd0);
        chk("idle_addr_hold", {16'd0, mem_addr}, 32'd800);
        step(9'd524, 10'd798);
        chk("eol_r524_re", {31'd0, mem_re}, 32'd1);
        chk("eol_r524_addr", {16'd0, mem_addr}, 32'd0);
        step(9'd0, 10'd14);
        chk("mid_c14_addr", {16'd0, mem_addr}, 32'd2);
        step(9'd0, 10'd630);
        chk("mid_c630_addr", {16'd0, mem_addr}, 32'd79);
        step(9'd0, 10'd638);
        chk("mid_c638_re", {31'd0, mem_re}, 32'd0);
        step(9'd479, 10'd6);
        chk("mid_r479_addr", {16'd0, mem_addr}, 32'd38321);
        step(9'd480, 10'd6);
        chk("mid_r480_re", {31'd0, mem_re}, 32'd0);
        chk("blank_pixel_valid", {31'd0, pixel_valid}, 32'd0);

        // Pixel shifter
        pat = 8'hA5;
        step(9'd0, 10'd7);
        mem_rdata = pat;
        for (int i = 0; i < 8; i++) begin
            step(9'd0, 10'(8 + i));
            mem_rdata = 8'h00;
            chk("pixel_bit", {31'd0, pixel}, {31'd0, pat[7-i]});
            chk("pixel_valid_on", {31'd0, pixel_valid}, 32'd1);
        end
        step(9'd0, 10'd639);
        chk("pv_c640", {31'd0, pixel_valid}, 32'd1);
        step(9'd0, 10'd640);
        chk("pv_c641", {31'd0, pixel_valid}, 32'd0);
        chk("pixel_c641", {31'd0, pixel}, 32'd0);

        // Write pending across a fetch slot; push and pop together at count 2
        step(9'd3, 10'd4);
        wr_valid = 1'b1;
        step(9'd3, 10'd5);
        step(9'd3, 10'd6);
        chk("c7_re", {31'd0, mem_re}, 32'd1);
        chk("c7_addr", {16'd0, mem_addr}, 32'd241);
        chk("c7_we", {31'd0, mem_we}, 32'd0);
        step(9'd3, 10'd7);
        wr_valid = 1'b0;
        chk("c8_we", {31'd0, mem_we}, 32'd1);
        step(9'd3, 10'd8);
        chk("c9_we", {31'd0, mem_we}, 32'd1);
        step(9'd3, 10'd9);
        chk("c10_we", {31'd0, mem_we}, 32'd1);
        step(9'd3, 10'd10);
        chk("c11_we", {31'd0, mem_we}, 32'd0);

        // Blanking drain
        wr_valid = 1'b1;
        for (int c = 636; c < 640; c++) step(9'd2, 10'(c));
        wr_valid = 1'b0;
        step(9'd2, 10'd640);
        chk("drain_we4", {31'd0, mem_we}, 32'd1);
        step(9'd2, 10'd641);
        chk("drain_done", {31'd0, mem_we}, 32'd0);
        for (int c = 642; c < 798; c++) begin
            step(9'd2, 10'(c));
            chk("blank_no_re", {31'd0, mem_re}, 32'd0);
        end
        step(9'd2, 10'd798);
        chk("blank_eol_re", {31'd0, mem_re}, 32'd1);
        chk("blank_eol_addr", {16'd0, mem_addr}, 32'd240);

        // FIFO fill under continuous host writes
        wr_valid = 1'b1;
        for (int c = 0; c < 32; c++) begin
            step(9'd0, 10'(c));
            if (c == 21) chk("ready_cnt3", {31'd0, wr_ready}, 32'd1);
            if (c == 22) chk("ready_full", {31'd0, wr_ready}, 32'd0);
            if (c == 23) chk("ready_after_pop", {31'd0, wr_ready}, 32'd1);
        end
        wr_valid = 1'b0;
        for (int c = 32; c < 48; c++) step(9'd0, 10'(c));
        chk("fifo_drained", sb.size(), 32'd0);

        // Reset mid-operation with three writes queued
        wr_valid = 1'b1;
        for (int c = 285; c < 300; c++) step(9'd100, 10'(c));
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        sb.delete();
        #1;
        chk("mrst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("mrst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("mrst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("mrst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("mrst_pixel", {30'd0, pixel, pixel_valid}, 32'd0);
        step(9'd100, 10'd300);
        step(9'd100, 10'd301);
        rst_n = 1'b1;
        for (int c = 302; c < 312; c++) begin
            step(9'd100, 10'(c));
            chk("post_rst_we", {31'd0, mem_we}, 32'd0);
            if (c == 302) chk("post_rst_fetch", {16'd0, mem_addr}, 32'd8038);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
